// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer.
// Holds funct3 decodes, state encoding and operand signedness helpers.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StCalc = S_CALC,
    StDone = S_DONE
  } state_e;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> M-extension sequencer handshake bundle.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srcA, srcB, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, srcA, srcB, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Lane-wise conditional two's-complement negation: magnitudes on the way in,
// final sign restoration on the way out.
module muldiv_sign_fix #(
  parameter int unsigned Width = 32,
  parameter int unsigned Lanes = 1
) (
  input  logic [Lanes-1:0][Width-1:0] val_i,
  input  logic [Lanes-1:0]            neg_i,
  output logic [Lanes-1:0][Width-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    for (int i = 0; i < Lanes; i++) begin
      if (neg_i[i]) res_o[i] = -val_i[i];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply, radix-2 restoring divide,
// one iteration per cycle, stalls EX while running and pulses done with the result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned ITER = XLEN_DEFAULT
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ITER);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic              res_neg_q, res_neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Input side: operand magnitudes (lane 1 = rs1, lane 0 = rs2)
  logic                       neg_a, neg_b;
  logic [1:0][XLEN-1:0]       mag;
  logic                       div_by_zero, div_ovf, accept;

  assign neg_a = rs1_signed(bus.funct3) & bus.srcA[XLEN-1];
  assign neg_b = rs2_signed(bus.funct3) & bus.srcB[XLEN-1];

  muldiv_sign_fix #(
    .Width(XLEN),
    .Lanes(2)
  ) u_in_fix (
    .val_i({bus.srcA, bus.srcB}),
    .neg_i({neg_a, neg_b}),
    .res_o(mag)
  );

  assign div_by_zero = bus.funct3[2] & (bus.srcB == '0);
  assign div_ovf     = bus.funct3[2] & ~bus.funct3[0]
                     & (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) & (bus.srcB == '1);
  // Reset gates the accept so no stall is claimed while held in reset.
  assign accept      = (state_q == StIdle) & bus.start & ~bus.flush & ~reset;

  // Output side: pick the raw value, then restore the sign over the full width
  logic                        is_mul, is_rem;
  logic [0:0][2*XLEN-1:0]      fix_in, fixed;
  logic [XLEN-1:0]             final_res;

  assign is_mul = ~f3_q[2];
  assign is_rem = f3_q[2] & f3_q[1];

  always_comb begin
    fix_in = '0;
    if (is_mul) fix_in[0] = acc_q;
    else        fix_in[0] = {{XLEN{1'b0}}, is_rem ? rem_q[XLEN-1:0] : quo_q};
  end

  muldiv_sign_fix #(
    .Width(2 * XLEN),
    .Lanes(1)
  ) u_out_fix (
    .val_i(fix_in),
    .neg_i(res_neg_q),
    .res_o(fixed)
  );

  assign final_res = ((f3_q == F3_MUL) || f3_q[2]) ? fixed[0][XLEN-1:0]
                                                   : fixed[0][2*XLEN-1:XLEN];

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift, div_diff;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {2'b00, opb_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_neg_d = res_neg_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d  = bus.funct3;
          opb_d = mag[0];
          cnt_d = '0;
          if (bus.funct3[2] & bus.funct3[1]) res_neg_d = neg_a;
          else if (div_by_zero)              res_neg_d = 1'b0;
          else                               res_neg_d = neg_a ^ neg_b;

          if (bus.funct3[2]) begin
            rem_d = '0;
            quo_d = mag[1];
          end else begin
            acc_d = {{XLEN{1'b0}}, mag[1]};
          end

          if (div_by_zero) begin
            quo_d   = '1;
            rem_d   = {1'b0, mag[1]};
            state_d = StDone;
          end else if (div_ovf) begin
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (is_mul) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end else if (div_diff[XLEN+1]) begin
            rem_d = div_shift[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d = div_diff[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(ITER - 1)) state_d = StDone;
        end
      end

      StDone: begin
        result_d = final_res;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      f3_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_neg_q <= res_neg_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.stall  = accept | (state_q == StCalc);
  // The freshly fixed value is visible during the done cycle, then held in result_q.
  assign bus.result = (state_q == StDone) ? final_res : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, stall shape, results, flush and async reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(
    .XLEN(32),
    .ITER(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op with start held until done, then verify latency, stall shape,
  // result, single-cycle done and no re-accept afterwards.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp, input string tag);
    int done_at;
    bit stall_ok;
    done_at  = -1;
    stall_ok = 1'b1;
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = f3;
    bus.srcA   = a;
    bus.srcB   = b;
    #1;
    check({tag, " accept_stall"}, {31'b0, bus.stall}, 32'd1);
    for (int n = 1; n <= lat + 4; n++) begin
      @(posedge clk);
      #2;
      if (bus.done) begin
        done_at = n;
        if (bus.stall) stall_ok = 1'b0;
        break;
      end
      if (!bus.stall) stall_ok = 1'b0;
    end
    check({tag, " latency"}, done_at, lat);
    check({tag, " stall_shape"}, {31'b0, stall_ok}, 32'd1);
    check({tag, " result"}, bus.result, exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    #1;
    check({tag, " after_done_busy"}, {30'b0, bus.done, bus.busy}, 32'd0);
    check({tag, " result_held"}, bus.result, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done_seen;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.srcA   = '0;
    bus.srcB   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset busy",   {31'b0, bus.busy},  32'd0);
    check("reset done",   {31'b0, bus.done},  32'd0);
    check("reset stall",  {31'b0, bus.stall}, 32'd0);
    check("reset result", bus.result,         32'd0);

    // start with flush in IDLE must not be accepted
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.srcA   = 32'd9;
    bus.srcB   = 32'd9;
    #1;
    check("idle_flush stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk);
    #2;
    check("idle_flush busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;

    do_op(F3_MUL,    32'd7,        32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, "mul_7_m3");
    do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, "mulhu_ff");
    do_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, "mulh_m1_m1");
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF, "mulhsu_m1_2");
    do_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFD, "div_m7_2");
    do_op(F3_REM,    32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, "rem_m7_2");
    do_op(F3_DIVU,   32'hFFFF_FFF9, 32'd2,        33, 32'h7FFF_FFFC, "divu_big_2");

    // flush mid-CALC: no done, result keeps previous value
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = F3_DIV;
    bus.srcA   = 32'd100;
    bus.srcB   = 32'd7;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    #1;
    check("flush calc_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush idle_busy", {31'b0, bus.busy}, 32'd0);
    check("flush no_stall",  {31'b0, bus.stall}, 32'd0);
    check("flush result",    bus.result, 32'h7FFF_FFFC);
    done_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2;
      if (bus.done) done_seen = 1'b1;
    end
    check("flush no_done", {31'b0, done_seen}, 32'd0);
    do_op(F3_REMU, 32'd100, 32'd7, 33, 32'd2, "remu_100_7");

    // special divide cases finish one cycle after accept
    do_op(F3_DIVU, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, "divu_5_0");
    do_op(F3_REM,  32'd5,         32'd0,         1, 32'h0000_0005, "rem_5_0");
    do_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    do_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "rem_ovf");
    do_op(F3_DIV,  32'hFFFF_FFF9, 32'd0,         1, 32'hFFFF_FFFF, "div_m7_0");
    do_op(F3_MUL,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, "mul_min_m1");
    do_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, "mulh_min_min");

    // asynchronous reset mid-CALC, start held across release
    bus.start  = 1'b1;
    bus.flush  = 1'b0;
    bus.funct3 = F3_MUL;
    bus.srcA   = 32'd3;
    bus.srcB   = 32'd5;
    repeat (5) @(posedge clk);
    #2;
    check("rst pre_busy", {31'b0, bus.busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst busy",   {31'b0, bus.busy},  32'd0);
    check("rst stall",  {31'b0, bus.stall}, 32'd0);
    check("rst done",   {31'b0, bus.done},  32'd0);
    check("rst result", bus.result,         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_op(F3_MUL, 32'd3, 32'd5, 33, 32'd15, "rst_resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
